sha256_msg_pad: RTL and testbench



---
 rtl/sha256_msg_pad_if.sv | 25 ++
 rtl/sha256_msg_pad.sv | 113 +++++++++++
 tb/tb_sha256_msg_pad.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_pad_if.sv
// Byte-stream input and padded-block output of the SHA-256 message padder.
interface sha256_msg_pad_if;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   in_data;
   logic         in_last;
   logic         in_empty;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         blk_first;
   logic         blk_last;

   // Padder side
   modport slave (
      input  in_valid, in_data, in_last, in_empty, blk_ready,
      output in_ready, blk_valid, blk_data, blk_first, blk_last
   );

   // Byte source / block consumer side
   modport master (
      output in_valid, in_data, in_last, in_empty, blk_ready,
      input  in_ready, blk_valid, blk_data, blk_first, blk_last
   );
endinterface

// File: rtl/sha256_msg_pad.sv
// SHA-256 message padder: collects bytes into a 512-bit buffer, appends the 0x80
// marker, zero fill and 64-bit big-endian bit length, and emits blocks flagged
// first/last of their message.
module sha256_msg_pad #(
   parameter int unsigned LEN_W = 64
) (
   input logic              clk,
   input logic              reset_n,
   sha256_msg_pad_if.slave  bus
);

   typedef enum logic [1:0] {StFill, StPad, StLen, StEmit} state_e;

   state_e             state_q;
   logic [511:0]       buf_q;
   logic [5:0]         ptr_q;
   logic [LEN_W-1:0]   len_q;
   logic               pad_pending_q;
   logic               len_pending_q;
   logic               first_q;
   logic               last_q;

   logic               accept;
   logic [8:0]         bit_hi;
   logic [63:0]        len_field;

   assign accept    = bus.in_valid && (state_q == StFill);
   // Byte 0 lives in the top byte lane, so byte ptr starts at bit 511 - 8*ptr.
   assign bit_hi    = 9'd511 - {ptr_q, 3'b000};
   assign len_field = 64'(len_q);

   // Single-process FSM: buffer fill, padding, length insertion and block hand-off
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StFill;
         buf_q         <= '0;
         ptr_q         <= '0;
         len_q         <= '0;
         pad_pending_q <= 1'b0;
         len_pending_q <= 1'b0;
         first_q       <= 1'b1;
         last_q        <= 1'b0;
      end else begin
         unique case (state_q)
            StFill: begin
               if (accept) begin
                  if (!bus.in_empty) begin
                     buf_q[bit_hi -: 8] <= bus.in_data;
                     ptr_q              <= ptr_q + 6'd1;
                     len_q              <= len_q + LEN_W'(8);
                     if (ptr_q == 6'd63) begin
                        // Full block: padding (if any) starts in a fresh block
                        state_q       <= StEmit;
                        last_q        <= 1'b0;
                        pad_pending_q <= bus.in_last;
                     end else if (bus.in_last) begin
                        state_q <= StPad;
                     end
                  end else if (bus.in_last) begin
                     state_q <= StPad;
                  end
               end
            end
            StPad: begin
               buf_q[bit_hi -: 8] <= 8'h80;
               if (ptr_q <= 6'd55) begin
                  buf_q[63:0] <= len_field;
                  last_q      <= 1'b1;
               end else begin
                  // No room for the length field; it goes in an extra block
                  last_q        <= 1'b0;
                  len_pending_q <= 1'b1;
               end
               state_q <= StEmit;
            end
            StLen: begin
               buf_q[63:0] <= len_field;
               last_q      <= 1'b1;
               state_q     <= StEmit;
            end
            StEmit: begin
               if (bus.blk_ready) begin
                  buf_q   <= '0;
                  ptr_q   <= '0;
                  first_q <= 1'b0;
                  if (pad_pending_q) begin
                     pad_pending_q <= 1'b0;
                     state_q       <= StPad;
                  end else if (len_pending_q) begin
                     len_pending_q <= 1'b0;
                     state_q       <= StLen;
                  end else if (last_q) begin
                     first_q <= 1'b1;
                     len_q   <= '0;
                     last_q  <= 1'b0;
                     state_q <= StFill;
                  end else begin
                     state_q <= StFill;
                  end
               end
            end
            default: state_q <= StFill;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == StFill);
   assign bus.blk_valid = (state_q == StEmit);
   assign bus.blk_data  = buf_q;
   assign bus.blk_first = first_q;
   assign bus.blk_last  = last_q;

endmodule

// File: tb/tb_sha256_msg_pad.sv
// Scoreboard bench for sha256_msg_pad: a padding model fills the expected-block
// queue when a message is issued; a monitor pops and compares on every handshake.
module tb_sha256_msg_pad;

   typedef struct {
      logic [511:0] data;
      bit           first;
      bit           last;
   } blk_t;

   logic clk;
   logic reset_n;
   sha256_msg_pad_if bus ();

   sha256_msg_pad #(.LEN_W(64)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;
   blk_t        exp_q[$];
   logic [7:0]  msg_q[$];
   bit          auto_ready = 1'b0;
   bit          drv_ready  = 1'b0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference padding: message || 0x80 || zeros to 56 mod 64 || 64-bit bit length
   task automatic model_push();
      logic [7:0]  p[$];
      logic [63:0] bits;
      int          nb;
      blk_t        b;
      p = msg_q;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      bits = 64'(msg_q.size()) * 64'd8;
      for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
      nb = p.size() / 64;
      for (int i = 0; i < nb; i++) begin
         b.data = '0;
         for (int j = 0; j < 64; j++) b.data[511-8*j -: 8] = p[64*i+j];
         b.first = (i == 0);
         b.last  = (i == nb - 1);
         exp_q.push_back(b);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic beat(input logic [7:0] d, input bit last, input bit empty);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      bus.in_empty = empty;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         n++;
         if (n > 300) begin
            vectors++;
            miscompares++;
            $display("FAIL in_accept_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_empty = 1'b0;
      bus.in_data  = 8'($urandom);
   endtask

   task automatic send_msg();
      model_push();
      if (msg_q.size() == 0) begin
         beat(8'($urandom), 1'b1, 1'b1);
      end else begin
         for (int i = 0; i < msg_q.size(); i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            // in_empty without in_last must be ignored
            if ($urandom_range(0, 7) == 0) beat(8'($urandom), 1'b0, 1'b1);
            beat(msg_q[i], (i == msg_q.size() - 1), 1'b0);
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         idle(1);
         n++;
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain_timeout: got %0d blocks outstanding expected 0", exp_q.size());
         exp_q.delete();
      end
      idle(2);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  512'(bus.in_ready),  512'(1));
      check({tag, "_blk_valid"}, 512'(bus.blk_valid), 512'(0));
      check({tag, "_blk_data"},  bus.blk_data,        512'(0));
      check({tag, "_blk_first"}, 512'(bus.blk_first), 512'(1));
      check({tag, "_blk_last"},  512'(bus.blk_last),  512'(0));
   endtask

   // Consumer: random or directed blk_ready, updated after the driver each cycle
   initial begin
      bus.blk_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         bus.blk_ready = auto_ready ? ($urandom_range(0, 3) != 0) : drv_ready;
      end
   end

   // Monitor: compare every accepted block against the scoreboard head
   initial begin
      blk_t e;
      forever begin
         @(negedge clk);
         if (reset_n && bus.blk_valid && bus.blk_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_block: got block %h expected none", bus.blk_data);
            end else begin
               e = exp_q.pop_front();
               check("blk_data",  bus.blk_data,        e.data);
               check("blk_first", 512'(bus.blk_first), 512'(e.first));
               check("blk_last",  512'(bus.blk_last),  512'(e.last));
            end
         end
      end
   end

   initial begin
      int len;
      reset_n      = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_last  = 1'b0;
      bus.in_empty = 1'b0;
      #20;
      check_reset_outputs("reset");
      #2 reset_n = 1'b1;
      @(posedge clk);
      #1;

      // "abc": latency and backpressure with blk_ready held low
      msg_q = '{8'h61, 8'h62, 8'h63};
      send_msg();
      @(negedge clk);
      check("abc_valid_1cyc", 512'(bus.blk_valid), 512'(0));
      @(negedge clk);
      check("abc_valid_2cyc", 512'(bus.blk_valid), 512'(1));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_valid",    512'(bus.blk_valid), 512'(1));
         check("bp_in_ready", 512'(bus.in_ready),  512'(0));
         check("bp_data",     bus.blk_data,        exp_q[0].data);
         check("bp_first",    512'(bus.blk_first), 512'(exp_q[0].first));
         check("bp_last",     512'(bus.blk_last),  512'(exp_q[0].last));
      end
      @(posedge clk);
      #1 drv_ready = 1'b1;
      idle(3);
      auto_ready = 1'b1;

      // Boundary messages
      msg_q.delete();
      send_msg();
      msg_q.delete();
      for (int i = 0; i < 55; i++) msg_q.push_back(8'h61);
      send_msg();
      msg_q.push_back(8'h61);
      send_msg();
      msg_q.delete();
      for (int i = 0; i < 64; i++) msg_q.push_back(8'(i));
      send_msg();
      drain();

      // Back-to-back random messages
      for (int m = 0; m < 2; m++) begin
         msg_q.delete();
         len = $urandom_range(1, 70);
         for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
         send_msg();
      end
      drain();

      // Asynchronous reset after 20 bytes of a message
      for (int i = 0; i < 20; i++) beat(8'($urandom | 1), 1'b0, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;
      msg_q = '{8'h61, 8'h62, 8'h63};
      send_msg();
      drain();

      // Randomised messages
      for (int m = 0; m < 25; m++) begin
         msg_q.delete();
         len = $urandom_range(0, 150);
         for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
         send_msg();
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
